// File: rtl/dmem_mmio_responder_if.sv
// Data-memory bus between the core (master) and the memory/MMIO responder (slave).
// The core drives byte-lane enables, address, write data and read/write requests.
// The responder returns registered read data and a combinational stall.
interface dmem_mmio_responder_if;
  logic [3:0]  mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_wea;
  logic        mem_rea;
  logic [31:0] mem_dout;
  logic        mem_hold;

  modport master (
    output mem_en, mem_addr, mem_din, mem_wea, mem_rea,
    input  mem_dout, mem_hold
  );

  modport slave (
    input  mem_en, mem_addr, mem_din, mem_wea, mem_rea,
    output mem_dout, mem_hold
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: byte-enabled RAM below address bit 15, and above it a small
// MMIO block with a UART transmitter fed by a TX FIFO. A byte store to a full FIFO
// stalls the core through mem_hold until the transmitter frees an entry.
module dmem_mmio_responder #(
  parameter int MEM_WORDS    = 1024,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 Rst,
  dmem_mmio_responder_if.slave bus,
  output logic                 uart_tx,
  output logic                 tx_busy
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Request decode
  logic          sel_mmio;
  logic [7:0]    offset;
  logic [AW-1:0] word_idx;
  logic          rd_req;
  logic          wr_ram;
  logic          txdata_store;
  logic [31:0]   lane_mask;

  assign sel_mmio     = bus.mem_addr[15];
  assign offset       = bus.mem_addr[7:0];
  assign word_idx     = bus.mem_addr[AW+1:2];
  assign rd_req       = bus.mem_rea & (bus.mem_en != 4'b0000);
  assign wr_ram       = bus.mem_wea & (bus.mem_en != 4'b0000) & ~sel_mmio;
  assign txdata_store = bus.mem_wea & sel_mmio & (offset == 8'h00) & bus.mem_en[0];

  // Only the word-index, MMIO-select and offset bits of the address are decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.mem_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane_mask
      assign lane_mask[8*gi +: 8] = {8{bus.mem_en[gi]}};
    end
  endgenerate

  // FIFO state
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_head;

  assign fifo_full    = (count_reg == COUNT_FULL);
  assign fifo_empty   = (count_reg == '0);
  assign push         = txdata_store & ~fifo_full;
  assign bus.mem_hold = txdata_store & fifo_full;
  assign fifo_head    = fifo_mem[rd_ptr_reg];

  // Transmitter state
  tx_state_t     state_reg, state_next;
  logic [BW-1:0] baud_reg, baud_next;
  logic [2:0]    idx_reg, idx_next;
  logic [7:0]    shifter_reg, shifter_next;
  logic          tx_reg, tx_next;
  logic          busy_reg, busy_next;

  assign uart_tx = tx_reg;
  assign tx_busy = busy_reg;

  // RAM: byte-lane writes, registered read; the non-blocking read gives read-first on wea&rea
  logic [31:0] ram [MEM_WORDS];
  logic [31:0] rd_word_reg;

  always_ff @(posedge clk) begin
    if (wr_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_en[i]) ram[word_idx][8*i +: 8] <= bus.mem_din[8*i +: 8];
      end
    end
    if (rd_req) rd_word_reg <= ram[word_idx];
  end

  // MMIO read mux, sampled at the read edge
  logic [31:0] mmio_rdata;

  always_comb begin
    mmio_rdata = '0;
    case (offset)
      8'h04:   mmio_rdata = {29'b0, fifo_full, fifo_empty, busy_reg};
      8'h08:   mmio_rdata = 32'(count_reg);
      default: mmio_rdata = '0;
    endcase
  end

  // Read-return registers; they change only on a read so mem_dout holds between reads
  logic        rd_mmio_reg;
  logic [31:0] rd_mask_reg;
  logic [31:0] mmio_rdata_reg;

  always_ff @(posedge clk) begin
    if (Rst) begin
      rd_mmio_reg    <= 1'b0;
      rd_mask_reg    <= '0;
      mmio_rdata_reg <= '0;
    end else if (rd_req) begin
      rd_mmio_reg    <= sel_mmio;
      rd_mask_reg    <= lane_mask;
      mmio_rdata_reg <= mmio_rdata;
    end
  end

  // A cleared lane mask makes RAM data read as zero straight out of reset
  assign bus.mem_dout = rd_mmio_reg ? mmio_rdata_reg : (rd_word_reg & rd_mask_reg);

  // FIFO storage, no reset needed on the data
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= bus.mem_din[7:0];
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged
  always_ff @(posedge clk) begin
    if (Rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // Transmitter state register; line output and busy are registered with the state
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      idx_reg     <= '0;
      shifter_reg <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      idx_reg     <= idx_next;
      shifter_reg <= shifter_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
    end
  end

  // Transmitter next state: 8N1 framing, baud counter restarts on every state or bit change
  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg + 1'b1;
    idx_next     = idx_reg;
    shifter_next = shifter_reg;
    pop          = 1'b0;
    tx_next      = 1'b1;
    case (state_reg)
      IDLE: begin
        baud_next = '0;
        if (!fifo_empty) begin
          pop          = 1'b1;
          shifter_next = fifo_head;
          state_next   = START;
        end
      end
      START: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next  = '0;
          idx_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next = '0;
          if (idx_reg == 3'd7) state_next = STOP;
          else                 idx_next   = idx_reg + 1'b1;
        end
      end
      STOP: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next  = '0;
          state_next = IDLE;
        end
      end
      default: begin
        baud_next  = '0;
        state_next = IDLE;
      end
    endcase
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shifter_next[idx_next];
      default: tx_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end
endmodule
